// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//
// Shares the single write port of the register set among NUM_REQ writeback
// requesters using round-robin arbitration. It also keeps a per-register
// busy scoreboard so that issue logic can detect read-after-write hazards.
// The write strobe, address and data go to the register set directly from
// flops.
//
// Ports
//   clk_i            clock, every state update is on the rising edge
//   reset_i          asynchronous active-high reset
//   req_valid_i      per-requester write pending
//   req_addr_i       requester i destination at [i*ADDR_W +: ADDR_W]
//   req_data_i       requester i data at [i*DATA_W +: DATA_W]
//   req_ready_o      one-hot grant (or zero); transfer = valid & ready
//   hold_i           blocks new grants while high
//   reserve_valid_i  issue stage marks reserve_addr_i busy
//   reserve_addr_i   register being reserved
//   write_enable_o   registered write strobe to the register set
//   write_address_o  registered write address
//   write_data_o     registered write data
//   busy_mask_o      registered scoreboard, bit r = write to r outstanding
//   reserve_error_o  one-cycle pulse: a reserve hit an already-busy register
module regfile_write_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      hold_i,
    input  logic                      reserve_valid_i,
    input  logic [ADDR_W-1:0]         reserve_addr_i,
    output logic                      write_enable_o,
    output logic [ADDR_W-1:0]         write_address_o,
    output logic [DATA_W-1:0]         write_data_o,
    output logic [NUM_REGS-1:0]       busy_mask_o,
    output logic                      reserve_error_o
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    // Registered state
    logic [PTR_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic                we_q,        we_d;
    logic [ADDR_W-1:0]   waddr_q,     waddr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [NUM_REGS-1:0] busy_q,      busy_d;
    logic                rsv_err_q,   rsv_err_d;

    // Per-requester views of the packed request buses
    logic [ADDR_W-1:0] req_addr_arr [NUM_REQ];
    logic [DATA_W-1:0] req_data_arr [NUM_REQ];

    // Candidate requester index for each search position, starting at rr_ptr_q
    logic [PTR_W:0]    cand_sum  [NUM_REQ];
    logic [PTR_W:0]    cand_wrap [NUM_REQ];
    logic [PTR_W-1:0]  cand_idx  [NUM_REQ];

    logic              grant_valid;
    logic [PTR_W-1:0]  grant_idx;
    logic              transfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
            assign req_data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];

            // rr_ptr_q + gi never exceeds 2*NUM_REQ-2, so one conditional
            // subtraction is enough to wrap it back into range.
            assign cand_sum[gi]  = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
            assign cand_wrap[gi] = (cand_sum[gi] >= (PTR_W+1)'(NUM_REQ))
                                   ? cand_sum[gi] - (PTR_W+1)'(NUM_REQ)
                                   : cand_sum[gi];
            assign cand_idx[gi]  = cand_wrap[gi][PTR_W-1:0];

            assign req_ready_o[gi] = transfer && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // First valid requester in rotating priority order
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && req_valid_i[cand_idx[k]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // Ready is suppressed while reset is asserted so nothing upstream sees
    // a handshake that the flops are not going to capture.
    assign transfer = grant_valid && !hold_i && !reset_i;

    // Arbiter pointer and write-port capture
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (transfer) begin
            we_d     = 1'b1;
            waddr_d  = req_addr_arr[grant_idx];
            wdata_d  = req_data_arr[grant_idx];
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Scoreboard: the clear from the committing write is applied first so
    // that a reserve of the same register in the same cycle wins (the new
    // producer owns the bit). The error looks at the pre-edge state, so a
    // reserve colliding with the final write of the previous producer still
    // flags.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (reserve_valid_i) begin
            busy_d[reserve_addr_i] = 1'b1;
        end
        rsv_err_d = reserve_valid_i && busy_q[reserve_addr_i];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q  <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    assign write_enable_o  = we_q;
    assign write_address_o = waddr_q;
    assign write_data_o    = wdata_q;
    assign busy_mask_o     = busy_q;
    assign reserve_error_o = rsv_err_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: a vector table covering
// arbitration, scoreboard and hold behaviour, followed by a hand-written
// sequence for asynchronous reset during an in-flight write and back-to-back
// grants to a single requester.
module tb_regfile_write_scheduler;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int NREGS   = 16;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      hold;
    logic                      rsv_valid;
    logic [ADDR_W-1:0]         rsv_addr;
    logic                      wen;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;
    logic [NREGS-1:0]          busy;
    logic                      rsv_err;

    int total  = 0;
    int passed = 0;

    regfile_write_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_REGS(NREGS)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .hold_i         (hold),
        .reserve_valid_i(rsv_valid),
        .reserve_addr_i (rsv_addr),
        .write_enable_o (wen),
        .write_address_o(waddr),
        .write_data_o   (wdata),
        .busy_mask_o    (busy),
        .reserve_error_o(rsv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        int          ov_idx;     // requester whose addr/data override the defaults
        logic [3:0]  ov_addr;
        logic [31:0] ov_data;
        logic        hold;
        logic        rv;
        logic [3:0]  ra;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [3:0]  e_wa;
        logic [31:0] e_wd;
        logic [15:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] valid, input int ov_idx,
                       input logic [3:0] ov_addr, input logic [31:0] ov_data,
                       input logic hold_v, input logic rv, input logic [3:0] ra,
                       input logic [2:0] er, input logic ewe, input logic [3:0] ewa,
                       input logic [31:0] ewd, input logic [15:0] eb, input logic ee);
        vec_t v;
        v.valid = valid;  v.ov_idx = ov_idx; v.ov_addr = ov_addr; v.ov_data = ov_data;
        v.hold = hold_v;  v.rv = rv;         v.ra = ra;
        v.e_ready = er;   v.e_we = ewe;      v.e_wa = ewa;        v.e_wd = ewd;
        v.e_busy = eb;    v.e_err = ee;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Default requester payloads: requester i writes reg i+1 with 0x1111_1111*(i+1)
    task automatic drive_reqs(input logic [2:0] valid, input int ov_idx,
                              input logic [3:0] ov_addr, input logic [31:0] ov_data);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = 4'(i + 1);
            req_data[i*DATA_W +: DATA_W] = 32'h1111_1111 * (i + 1);
            if (i == ov_idx) begin
                req_addr[i*ADDR_W +: ADDR_W] = ov_addr;
                req_data[i*DATA_W +: DATA_W] = ov_data;
            end
        end
        req_valid = valid;
    endtask

    task automatic check_outputs(input int idx, input logic [2:0] er, input logic ewe,
                                 input logic [3:0] ewa, input logic [31:0] ewd,
                                 input logic [15:0] eb, input logic ee);
        chk("req_ready", idx, 32'(req_ready), 32'(er));
        chk("write_enable", idx, 32'(wen), 32'(ewe));
        chk("write_address", idx, 32'(waddr), 32'(ewa));
        chk("write_data", idx, wdata, ewd);
        chk("busy_mask", idx, 32'(busy), 32'(eb));
        chk("reserve_error", idx, 32'(rsv_err), 32'(ee));
    endtask

    initial begin
        reset     = 1'b1;
        hold      = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        drive_reqs(3'b000, -1, 4'd0, 32'd0);

        //   valid   ov  oaddr  odata          hold rv ra     ready   we wa     wdata          busy        err
        add(3'b010,  1, 4'd5, 32'hDEADBEEF,   0,  0, 4'd0,  3'b010, 0, 4'd0, 32'h00000000, 16'h0000, 0); // 0
        add(3'b000, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b000, 1, 4'd5, 32'hDEADBEEF, 16'h0000, 0); // 1
        add(3'b111, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b100, 0, 4'd5, 32'hDEADBEEF, 16'h0000, 0); // 2
        add(3'b111, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b001, 1, 4'd3, 32'h33333333, 16'h0000, 0); // 3
        add(3'b111, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b010, 1, 4'd1, 32'h11111111, 16'h0000, 0); // 4
        add(3'b111, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b100, 1, 4'd2, 32'h22222222, 16'h0000, 0); // 5
        add(3'b111, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b001, 1, 4'd3, 32'h33333333, 16'h0000, 0); // 6
        add(3'b111, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b010, 1, 4'd1, 32'h11111111, 16'h0000, 0); // 7
        add(3'b111, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b100, 1, 4'd2, 32'h22222222, 16'h0000, 0); // 8
        add(3'b000, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b000, 1, 4'd3, 32'h33333333, 16'h0000, 0); // 9
        add(3'b000, -1, 4'd0, 32'h0,          0,  1, 4'd7,  3'b000, 0, 4'd3, 32'h33333333, 16'h0000, 0); // 10
        add(3'b001,  0, 4'd7, 32'hCAFE0007,   0,  0, 4'd0,  3'b001, 0, 4'd3, 32'h33333333, 16'h0080, 0); // 11
        add(3'b000, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b000, 1, 4'd7, 32'hCAFE0007, 16'h0080, 0); // 12
        add(3'b000, -1, 4'd0, 32'h0,          0,  1, 4'd3,  3'b000, 0, 4'd7, 32'hCAFE0007, 16'h0000, 0); // 13
        add(3'b000, -1, 4'd0, 32'h0,          0,  1, 4'd3,  3'b000, 0, 4'd7, 32'hCAFE0007, 16'h0008, 0); // 14
        add(3'b000, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b000, 0, 4'd7, 32'hCAFE0007, 16'h0008, 1); // 15
        add(3'b000, -1, 4'd0, 32'h0,          0,  1, 4'd9,  3'b000, 0, 4'd7, 32'hCAFE0007, 16'h0008, 0); // 16
        add(3'b010,  1, 4'd9, 32'h99990009,   0,  0, 4'd0,  3'b010, 0, 4'd7, 32'hCAFE0007, 16'h0208, 0); // 17
        add(3'b000, -1, 4'd0, 32'h0,          0,  1, 4'd9,  3'b000, 1, 4'd9, 32'h99990009, 16'h0208, 0); // 18
        add(3'b000, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b000, 0, 4'd9, 32'h99990009, 16'h0208, 1); // 19
        add(3'b111, -1, 4'd0, 32'h0,          1,  0, 4'd0,  3'b000, 0, 4'd9, 32'h99990009, 16'h0208, 0); // 20
        add(3'b100,  2, 4'd4, 32'h44444444,   0,  0, 4'd0,  3'b100, 0, 4'd9, 32'h99990009, 16'h0208, 0); // 21
        add(3'b111, -1, 4'd0, 32'h0,          1,  0, 4'd0,  3'b000, 1, 4'd4, 32'h44444444, 16'h0208, 0); // 22
        add(3'b111, -1, 4'd0, 32'h0,          1,  0, 4'd0,  3'b000, 0, 4'd4, 32'h44444444, 16'h0208, 0); // 23
        add(3'b000, -1, 4'd0, 32'h0,          0,  0, 4'd0,  3'b000, 0, 4'd4, 32'h44444444, 16'h0208, 0); // 24

        // Reset state, with requesters valid to show ready is gated off
        @(posedge clk);
        @(posedge clk);
        #1;
        drive_reqs(3'b111, -1, 4'd0, 32'd0);
        #1;
        check_outputs(-1, 3'b000, 1'b0, 4'd0, 32'd0, 16'h0000, 1'b0);
        drive_reqs(3'b000, -1, 4'd0, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table: inputs applied just after an edge, outputs checked mid-cycle
        for (int r = 0; r < tbl.size(); r++) begin
            drive_reqs(tbl[r].valid, tbl[r].ov_idx, tbl[r].ov_addr, tbl[r].ov_data);
            hold      = tbl[r].hold;
            rsv_valid = tbl[r].rv;
            rsv_addr  = tbl[r].ra;
            #3;
            check_outputs(r, tbl[r].e_ready, tbl[r].e_we, tbl[r].e_wa, tbl[r].e_wd,
                          tbl[r].e_busy, tbl[r].e_err);
            @(posedge clk);
            #1;
        end
        hold      = 1'b0;
        rsv_valid = 1'b0;

        // Asynchronous reset while a captured write is on the port
        drive_reqs(3'b001, 0, 4'hA, 32'hAAAAAAAA);
        #3;
        chk("rst_seq_ready", 100, 32'(req_ready), 32'(3'b001));
        @(posedge clk);
        #1;
        chk("rst_seq_we_before", 101, 32'(wen), 32'd1);
        chk("rst_seq_wa_before", 102, 32'(waddr), 32'hA);
        #1;
        reset = 1'b1;
        #1;
        check_outputs(103, 3'b000, 1'b0, 4'd0, 32'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_seq_we_held", 104, 32'(wen), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_seq_ready_after", 105, 32'(req_ready), 32'(3'b001));

        // Back-to-back grants to a lone requester
        drive_reqs(3'b010, 1, 4'hB, 32'hBBBB000B);
        #1;
        chk("b2b_ready0", 106, 32'(req_ready), 32'(3'b010));
        @(posedge clk);
        #1;
        chk("b2b_we0", 107, 32'(wen), 32'd1);
        chk("b2b_wa0", 108, 32'(waddr), 32'hB);
        chk("b2b_wd0", 109, wdata, 32'hBBBB000B);
        chk("b2b_ready1", 110, 32'(req_ready), 32'(3'b010));
        @(posedge clk);
        #1;
        drive_reqs(3'b000, -1, 4'd0, 32'd0);
        chk("b2b_we1", 111, 32'(wen), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_we_drop", 112, 32'(wen), 32'd0);
        chk("b2b_busy", 113, 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the single write port of the 16x32 register set among several writeback requesters using round-robin arbitration. It also keeps a per-register busy scoreboard so that issue logic can detect read-after-write hazards. The block sits between the execution/load units and the register set, and drives that block's writeEnable/writeAddress/writeData inputs directly from registers.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..4)
- ADDR_W, 4, register address width
- DATA_W, 32, register data width
- NUM_REGS, 16, registers tracked by scoreboard (2**ADDR_W)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- reqValid  in  NUM_REQ  requester i has a write pending
- reqAddr  in  NUM_REQ*ADDR_W  requester i destination at [i*ADDR_W +: ADDR_W]
- reqData  in  NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
- reqReady  out  NUM_REQ  one-hot grant or zero; a transfer occurs when reqValid[i] & reqReady[i]
- hold  in  1  when high, no grant is issued
- reserveValid  in  1  issue stage marks reserveAddr busy
- reserveAddr  in  ADDR_W  register being reserved
- writeEnable  out  1  registered write strobe to register set
- writeAddress  out  ADDR_W  registered write address
- writeData  out  DATA_W  registered write data
- busyMask  out  NUM_REGS  registered scoreboard; bit r high means a write to r is outstanding
- reserveError  out  1  one-cycle pulse; a reserve hit an already-busy register

## Operation
- Round-robin pointer rrPtr ranges 0..NUM_REQ-1. Search order is rrPtr, rrPtr+1, ... with wrap modulo NUM_REQ. The first requester with reqValid high is granted.
- reqReady is combinational from reqValid, rrPtr and hold. It is all-zero when hold=1, when no reqValid is set, or while reset is high.
- On a transfer from requester g:
  - writeEnable<=1, writeAddress<=reqAddr[g], writeData<=reqData[g].
  - rrPtr<=(g+1) mod NUM_REQ.
- With no transfer: writeEnable<=0, writeAddress and writeData hold their values, rrPtr holds.
- Requesters must keep valid, addr and data stable until accepted, and must not wait for reqReady before asserting reqValid.
- Scoreboard, evaluated per edge:
  - set: reserveValid sets busyMask[reserveAddr].
  - clear: writeEnable=1 clears busyMask[writeAddress]. This is the same edge on which the register set commits the data.
  - Same register set and cleared in one cycle: set wins, bit stays 1 (a new producer owns it).
  - Reserve of an already-busy bit: bit stays 1, and reserveError=1 for the following cycle only.
  - Writing a non-busy register is legal; no error, bit stays 0.
- No register is special-cased; register 0 is writable and tracked like the others.

## Timing
- Reset values: writeEnable=0, writeAddress=0, writeData=0, busyMask=0, reserveError=0, rrPtr=0, reqReady=0.
- Reset mid-operation: a captured but uncommitted write is dropped because writeEnable is forced to 0. All busy bits are cleared.
- Accept latency:
  - Transfer at edge N sets writeEnable high in cycle N..N+1.
  - The register set writes at edge N+1, and the busy bit clears at edge N+1.
  - From cycle N+1 onward, read data is new and the busy bit is 0.
- Throughput is one write per cycle. Back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,0,... Each requester waits at most NUM_REQ-1 cycles.
- hold only blocks new grants; an already-captured write still completes.

## Test plan
- Reset release, then requester 1 valid with addr=5 and data=0xDEADBEEF -> reqReady=3'b010 the same cycle; next cycle writeEnable=1, writeAddress=5, writeData=0xDEADBEEF; following cycle writeEnable=0.
- All three requesters valid for 6 cycles with rrPtr=0 -> grant order 0,1,2,0,1,2; writeEnable high for 6 consecutive cycles.
- reserveValid with addr=7 -> busyMask[7]=1; then requester 0 writes reg 7 -> busyMask[7] returns to 0 one edge after the writeEnable cycle begins.
- Reserve reg 3 twice with no write in between -> reserveError high exactly one cycle after the second reserve; busyMask[3] stays 1.
- Same cycle: writeEnable=1 to reg 9 and reserveValid to reg 9 (already busy) -> busyMask[9] remains 1; reserveError pulses.
- Assert hold with requesters valid -> reqReady=0 and writeEnable drops to 0 after the in-flight write. Then assert reset asynchronously during writeEnable=1 -> all outputs go to 0 immediately.
